button_conditioner: RTL and testbench
=====================================

# button_conditioner

User-input front end for the digital clock: conditions the Nexys4 DDR push-buttons that set the time and the LED alarm. It is the input-side counterpart of the seven-segment display path. It synchronises and debounces each raw button, then emits clean levels and single-cycle press and release strobes. Optional hold-to-repeat strobes let the time-setting logic step digits rapidly. It runs directly on the 100 MHz system clock and feeds the clock/alarm control FSM.

## Interface
- N_BTN, 5, number of buttons (C, U, D, L, R); must be ≥ 1
- DEBOUNCE_CYCLES, 1_000_000, cycles a changed input must stay stable before it is accepted (10 ms); must be ≥ 2
- REPEAT_DELAY_CYCLES, 50_000_000, cycles from the press strobe to the first repeat strobe (500 ms); must be ≥ 2
- REPEAT_PERIOD_CYCLES, 10_000_000, cycles between subsequent repeat strobes (100 ms); must be ≥ 2
- CLK100MHZ  in  1  system clock; all outputs are synchronous to it
- CPU_RESETN  in  1  asynchronous, active-low reset
- btn_raw  in  N_BTN  raw pad levels; asynchronous and bouncy; 1 = pressed
- btn_level  out  N_BTN  debounced level
- btn_press  out  N_BTN  one-cycle strobe on a debounced 0→1 transition
- btn_release  out  N_BTN  one-cycle strobe on a debounced 1→0 transition
- btn_repeat  out  N_BTN  one-cycle auto-repeat strobe while a button is held

## Operation
- Reset: all flops clear asynchronously. btn_level, btn_press, btn_release and btn_repeat all reset to 0. Counters reset to 0; repeat FSMs reset to IDLE.
- Synchroniser: a 2-flop synchroniser per bit feeds the debouncer. Only the second stage is used.
- Debounce, per button, with counter cnt:
  - While the synchronised input differs from btn_level, cnt increments.
  - When cnt == DEBOUNCE_CYCLES-1 and the input still differs, btn_level toggles at the next edge and cnt clears.
  - Any cycle in which the input equals btn_level clears cnt. A glitch therefore restarts qualification.
- Strobes:
  - btn_press is registered and is high exactly in the first cycle btn_level reads 1.
  - btn_release behaves the same way for the first cycle btn_level reads 0.
- Auto-repeat FSM, per button, states IDLE / DELAY / REPEAT:
  - IDLE → DELAY on the press strobe; the repeat counter clears.
  - In DELAY, when the counter reaches REPEAT_DELAY_CYCLES, btn_repeat pulses and the FSM moves to REPEAT with the counter cleared.
  - In REPEAT, btn_repeat pulses every REPEAT_PERIOD_CYCLES.
  - A debounced release from DELAY or REPEAT returns the FSM to IDLE. No repeat strobe is issued in the release cycle, or after it.
- Buttons are fully independent. Simultaneous presses produce simultaneous, independent strobes.
- Counter widths are $clog2(param+1). Counters saturate by construction: they clear on every terminal count.
- Button held through reset release: the debouncer sees 0→1 and produces a normal btn_press after the debounce latency.

## Timing
- Latency from raw input to btn_level: btn_level changes after the (DEBOUNCE_CYCLES+2)-th consecutive rising edge sampling the new raw value. This is 2 synchroniser edges plus DEBOUNCE_CYCLES qualification edges.
- btn_press and btn_release coincide with the first cycle of the new btn_level.
- Repeat strobes, with the press strobe in cycle P:
  - First strobe in cycle P + REPEAT_DELAY_CYCLES.
  - Subsequent strobes in cycles P + REPEAT_DELAY_CYCLES + k·REPEAT_PERIOD_CYCLES, k ≥ 1.
- A raw pulse shorter than DEBOUNCE_CYCLES stable synchronised cycles produces no output activity.

## Configuration
- BTN_AUTOREPEAT_EN defined:
  - The repeat FSMs and counters are built.
  - btn_repeat behaves as described above.
- BTN_AUTOREPEAT_EN undefined:
  - No repeat logic is generated.
  - btn_repeat is tied to 0 and the port remains present.
  - btn_level, btn_press and btn_release are unchanged.

## Structure
- Package btn_pkg holds:
  - the rep_state_t enum (IDLE, DELAY, REPEAT);
  - default cycle constants;
  - button index localparams BTN_C=0, BTN_U=1, BTN_D=2, BTN_L=3, BTN_R=4.
- Sub-module btn_channel contains one synchroniser, the debouncer and the optional repeat FSM.
- The top replicates btn_channel N_BTN times in a generate loop.

## Test plan
All scenarios use DEBOUNCE_CYCLES=4, REPEAT_DELAY_CYCLES=20, REPEAT_PERIOD_CYCLES=8, with BTN_AUTOREPEAT_EN defined unless stated.
- Reset with CPU_RESETN=0 mid-operation while btn_raw=5'b11111 → all outputs 0 within the same cycle and held. After release, btn_level=5'b11111 on the 6th edge, with one btn_press strobe per bit.
- Raw bounce on bit 0 (1 for 3 cycles, 0 for 2, then steady 1) → single btn_press[0], asserted 6 edges after the steady-1 onset. No release strobe.
- Hold bit 1 for 60 cycles after its press strobe at cycle P → btn_repeat[1] at P+20, P+28, P+36, P+44, P+52 only.
- Release bit 1 at P+30 (raw) → btn_release[1] 6 edges later. No further btn_repeat[1]; the FSM is back in IDLE.
- Press bits 2 and 4 on the same edge → btn_press[2] and btn_press[4] in the same cycle. Other bits stay quiet.
- Compile without BTN_AUTOREPEAT_EN and hold a button for 100 cycles → btn_repeat stays 0. Press and release strobes are identical to the enabled build.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared definitions for the push-button front end of the digital clock.
//
// Contents:
//    rep_state_t        auto-repeat FSM states (IDLE, DELAY, REPEAT)
//    DEF_*_CYCLES       default timing constants for a 100 MHz clock
//    BTN_C .. BTN_R     bit positions of the Nexys4 DDR buttons in btn_* vectors
//    max_u()            helper used to size shared counters
package btn_pkg;

   typedef enum logic [1:0] {
      IDLE,
      DELAY,
      REPEAT
   } rep_state_t;

   // 10 ms debounce, 500 ms until the first repeat, then one repeat every 100 ms
   localparam int unsigned DEF_DEBOUNCE_CYCLES      = 1_000_000;
   localparam int unsigned DEF_REPEAT_DELAY_CYCLES  = 50_000_000;
   localparam int unsigned DEF_REPEAT_PERIOD_CYCLES = 10_000_000;

   localparam int unsigned BTN_C = 0;
   localparam int unsigned BTN_U = 1;
   localparam int unsigned BTN_D = 2;
   localparam int unsigned BTN_L = 3;
   localparam int unsigned BTN_R = 4;

   function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button lane: 2-flop synchroniser, debouncer, press/release strobes and,
// when BTN_AUTOREPEAT_EN is defined, the hold-to-repeat FSM.
//
// Ports:
//    clk        system clock
//    rst_n      asynchronous active-low reset
//    raw_i      raw, bouncy pad level (1 = pressed)
//    level_o    debounced level
//    press_o    one-cycle strobe in the first cycle level_o reads 1
//    release_o  one-cycle strobe in the first cycle level_o reads 0
//    repeat_o   one-cycle auto-repeat strobe while held (0 without BTN_AUTOREPEAT_EN)
module btn_channel
   import btn_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
   parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
   input  logic clk,
   input  logic rst_n,
   input  logic raw_i,
   output logic level_o,
   output logic press_o,
   output logic release_o,
   output logic repeat_o
);

   localparam int unsigned     DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
   localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync1_d;
   logic            sync2_q, sync2_d;
   logic [DB_W-1:0] db_cnt_q, db_cnt_d;
   logic            level_q, level_d;
   logic            press_q, press_d;
   logic            rel_q, rel_d;

   // The counter only advances while the synchronised input disagrees with the
   // accepted level; any agreeing cycle drops it to zero so a glitch restarts
   // qualification from scratch.
   always_comb begin
      sync1_d  = raw_i;
      sync2_d  = sync1_q;
      db_cnt_d = '0;
      level_d  = level_q;
      if (sync2_q != level_q) begin
         if (db_cnt_q == DB_LAST) begin
            level_d = ~level_q;
         end else begin
            db_cnt_d = db_cnt_q + DB_W'(1);
         end
      end
      press_d = level_d & ~level_q;
      rel_d   = ~level_d & level_q;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q  <= 1'b0;
         sync2_q  <= 1'b0;
         db_cnt_q <= '0;
         level_q  <= 1'b0;
         press_q  <= 1'b0;
         rel_q    <= 1'b0;
      end else begin
         sync1_q  <= sync1_d;
         sync2_q  <= sync2_d;
         db_cnt_q <= db_cnt_d;
         level_q  <= level_d;
         press_q  <= press_d;
         rel_q    <= rel_d;
      end
   end

   assign level_o   = level_q;
   assign press_o   = press_q;
   assign release_o = rel_q;

`ifdef BTN_AUTOREPEAT_EN
   localparam int unsigned      REP_W     = $clog2(max_u(REPEAT_DELAY_CYCLES, REPEAT_PERIOD_CYCLES) + 1);
   localparam logic [REP_W-1:0] RD_LAST   = REP_W'(REPEAT_DELAY_CYCLES - 1);
   localparam logic [REP_W-1:0] RP_LAST   = REP_W'(REPEAT_PERIOD_CYCLES - 1);

   rep_state_t       state_q, state_d;
   logic [REP_W-1:0] rep_cnt_q, rep_cnt_d;
   logic             repeat_q, repeat_d;

   // The FSM leaves IDLE on the same edge that raises press_o, so the counter
   // holds "cycles since the press strobe" and its terminal value is one less
   // than the delay/period. A release always wins over a due repeat strobe.
   always_comb begin
      state_d   = state_q;
      rep_cnt_d = rep_cnt_q;
      repeat_d  = 1'b0;
      unique case (state_q)
         IDLE: begin
            rep_cnt_d = '0;
            if (press_d) begin
               state_d = DELAY;
            end
         end
         DELAY: begin
            if (rel_d) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (rep_cnt_q == RD_LAST) begin
               repeat_d  = 1'b1;
               state_d   = REPEAT;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
         end
         REPEAT: begin
            if (rel_d) begin
               state_d   = IDLE;
               rep_cnt_d = '0;
            end else if (rep_cnt_q == RP_LAST) begin
               repeat_d  = 1'b1;
               rep_cnt_d = '0;
            end else begin
               rep_cnt_d = rep_cnt_q + REP_W'(1);
            end
         end
         default: begin
            state_d   = IDLE;
            rep_cnt_d = '0;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= IDLE;
         rep_cnt_q <= '0;
         repeat_q  <= 1'b0;
      end else begin
         state_q   <= state_d;
         rep_cnt_q <= rep_cnt_d;
         repeat_q  <= repeat_d;
      end
   end

   assign repeat_o = repeat_q;
`else
   assign repeat_o = 1'b0;
`endif

endmodule

// File: rtl/button_conditioner.sv
// Push-button conditioner for the digital clock: synchronises and debounces
// every Nexys4 DDR button and produces clean levels plus press, release and
// (optionally) hold-to-repeat strobes for the clock/alarm control FSM.
//
// Build option: define BTN_AUTOREPEAT_EN to build the auto-repeat logic;
// without it btn_repeat is tied to 0 and the port is kept.
//
// Ports:
//    CLK100MHZ    100 MHz system clock; all outputs are synchronous to it
//    CPU_RESETN   asynchronous active-low reset
//    btn_raw      raw pad levels, 1 = pressed
//    btn_level    debounced levels
//    btn_press    one-cycle strobes on debounced 0->1
//    btn_release  one-cycle strobes on debounced 1->0
//    btn_repeat   one-cycle auto-repeat strobes while held
module button_conditioner
   import btn_pkg::*;
#(
   parameter int unsigned N_BTN                = 5,
   parameter int unsigned DEBOUNCE_CYCLES      = DEF_DEBOUNCE_CYCLES,
   parameter int unsigned REPEAT_DELAY_CYCLES  = DEF_REPEAT_DELAY_CYCLES,
   parameter int unsigned REPEAT_PERIOD_CYCLES = DEF_REPEAT_PERIOD_CYCLES
) (
   input  logic             CLK100MHZ,
   input  logic             CPU_RESETN,
   input  logic [N_BTN-1:0] btn_raw,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_repeat
);

   // Buttons share nothing but clock and reset.
   for (genvar i = 0; i < int'(N_BTN); i++) begin : g_btn
      btn_channel #(
         .DEBOUNCE_CYCLES     (DEBOUNCE_CYCLES),
         .REPEAT_DELAY_CYCLES (REPEAT_DELAY_CYCLES),
         .REPEAT_PERIOD_CYCLES(REPEAT_PERIOD_CYCLES)
      ) u_channel (
         .clk      (CLK100MHZ),
         .rst_n    (CPU_RESETN),
         .raw_i    (btn_raw[i]),
         .level_o  (btn_level[i]),
         .press_o  (btn_press[i]),
         .release_o(btn_release[i]),
         .repeat_o (btn_repeat[i])
      );
   end

endmodule

// File: tb/tb_button_conditioner.sv
module tb_button_conditioner;

   localparam int N    = 5;
   localparam int DB   = 4;
   localparam int RD   = 20;
   localparam int RP   = 8;
   localparam int MAXE = 20000;
`ifdef BTN_AUTOREPEAT_EN
   localparam bit REP_EN = 1'b1;
`else
   localparam bit REP_EN = 1'b0;
`endif

   logic         clk = 1'b0;
   logic         rst_n = 1'b0;
   logic [N-1:0] raw = '0;
   logic [N-1:0] btn_level, btn_press, btn_release, btn_repeat;

   int tests = 0;
   int fails = 0;

   // Reference model state: raw history indexed by edge number since reset
   logic [N-1:0] hist [0:MAXE];
   int           e;
   logic [N-1:0] m_level, m_press, m_rel, m_rep;
   int           last_tog [N];
   int           press_edge [N];

   button_conditioner #(
      .N_BTN               (N),
      .DEBOUNCE_CYCLES     (DB),
      .REPEAT_DELAY_CYCLES (RD),
      .REPEAT_PERIOD_CYCLES(RP)
   ) dut (
      .CLK100MHZ  (clk),
      .CPU_RESETN (rst_n),
      .btn_raw    (raw),
      .btn_level  (btn_level),
      .btn_press  (btn_press),
      .btn_release(btn_release),
      .btn_repeat (btn_repeat)
   );

   always #5 clk = ~clk;

   task automatic model_reset();
      e       = 0;
      m_level = '0;
      m_press = '0;
      m_rel   = '0;
      m_rep   = '0;
      for (int b = 0; b < N; b++) begin
         last_tog[b]   = -1000000;
         press_edge[b] = 0;
      end
   endtask

   // Advance one rising edge and update the model. A level is accepted once the
   // raw value seen two edges late has disagreed with it on DB consecutive edges,
   // all after the previous acceptance. Repeats follow the press edge arithmetically.
   task automatic tick();
      logic s;
      logic tog;
      int   d;
      @(posedge clk);
      if (!rst_n) begin
         model_reset();
         #1;
         return;
      end
      if (e < MAXE) e++;
      hist[e] = raw;
      m_press = '0;
      m_rel   = '0;
      m_rep   = '0;
      for (int b = 0; b < N; b++) begin
         tog = (e - last_tog[b] >= DB);
         for (int k = e - DB + 1; k <= e; k++) begin
            s = (k >= 3) ? hist[k-2][b] : 1'b0;
            if (s == m_level[b]) tog = 1'b0;
         end
         if (tog) begin
            m_level[b]  = ~m_level[b];
            last_tog[b] = e;
            if (m_level[b]) begin
               m_press[b]    = 1'b1;
               press_edge[b] = e;
            end else begin
               m_rel[b] = 1'b1;
            end
         end else if (REP_EN && m_level[b]) begin
            d = e - press_edge[b];
            if (d >= RD && (d - RD) % RP == 0) m_rep[b] = 1'b1;
         end
      end
      #1;
   endtask

   task automatic test_reset();
      int pcnt;
      rst_n = 1'b0;
      raw   = '0;
      model_reset();
      repeat (3) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== '0)
            begin fails++; $display("[TB] FAIL reset_init: got %b_%b_%b_%b required all 0", btn_level, btn_press, btn_release, btn_repeat); end
      end
      rst_n = 1'b1;
      raw   = '1;
      for (int t = 1; t <= 10; t++) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL reset_rise edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
      end
      #3 rst_n = 1'b0;
      #1;
      tests++;
      if ({btn_level, btn_press, btn_release, btn_repeat} !== '0)
         begin fails++; $display("[TB] FAIL reset_async: got %b_%b_%b_%b required all 0", btn_level, btn_press, btn_release, btn_repeat); end
      model_reset();
      repeat (3) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== '0)
            begin fails++; $display("[TB] FAIL reset_hold: got %b_%b_%b_%b required all 0", btn_level, btn_press, btn_release, btn_repeat); end
      end
      rst_n = 1'b1;
      pcnt  = 0;
      for (int t = 1; t <= 8; t++) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL reset_relrise edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         if (t == 5) begin
            tests++;
            if (btn_level !== 5'b00000)
               begin fails++; $display("[TB] FAIL reset_edge5: level %b required 00000", btn_level); end
         end
         if (t == 6) begin
            tests++;
            if ({btn_level, btn_press} !== {5'b11111, 5'b11111})
               begin fails++; $display("[TB] FAIL reset_edge6: level %b press %b required 11111 11111", btn_level, btn_press); end
         end
         for (int b = 0; b < N; b++) pcnt += int'(btn_press[b]);
      end
      tests++;
      if (pcnt != 5) begin fails++; $display("[TB] FAIL reset_presscount: got %0d required 5", pcnt); end
   endtask

   task automatic test_bounce();
      int press_at, pcnt, rcnt;
      logic [N-1:0] pat [0:4];
      pat[0] = 5'b00001; pat[1] = 5'b00001; pat[2] = 5'b00001; pat[3] = 5'b00000; pat[4] = 5'b00000;
      press_at = -1; pcnt = 0; rcnt = 0;
      raw = '0;
      for (int t = 0; t < 22; t++) begin
         if (t >= 10 && t < 15) raw = pat[t-10];
         if (t == 15) raw = 5'b00001;
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL bounce edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         if (t >= 10) begin
            if (btn_press[0]) begin pcnt++; press_at = t - 14; end
            if (btn_release[0]) rcnt++;
         end
      end
      tests++;
      if (pcnt != 1 || rcnt != 0 || press_at != 6)
         begin fails++; $display("[TB] FAIL bounce_strobes: presses %0d releases %0d at edge %0d required 1 0 6", pcnt, rcnt, press_at); end
   endtask

   task automatic test_repeat_hold();
      int got [$];
      int want [$];
      bit seen;
      raw = '0;
      for (int t = 0; t < 10; t++) tick();
      model_reset_check: begin end
      raw[1] = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 15 && !seen; t++) begin
         tick();
         if (btn_press[1]) seen = 1'b1;
      end
      tests++;
      if (!seen) begin fails++; $display("[TB] FAIL hold_press: no press strobe within 15 edges"); end
      for (int k = 1; k <= 70; k++) begin
         if (k == 53) raw[1] = 1'b0;
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL hold edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         if (btn_repeat[1]) got.push_back(k);
      end
      if (REP_EN) want = '{20, 28, 36, 44, 52};
      tests++;
      if (got != want)
         begin fails++; $display("[TB] FAIL hold_repeats: got %p required %p", got, want); end
   endtask

   task automatic test_release_repeat();
      int got [$];
      int want [$];
      int rel_at;
      bit seen;
      raw = '0;
      for (int t = 0; t < 10; t++) tick();
      raw[1] = 1'b1;
      seen = 1'b0;
      for (int t = 0; t < 15 && !seen; t++) begin
         tick();
         if (btn_press[1]) seen = 1'b1;
      end
      tests++;
      if (!seen) begin fails++; $display("[TB] FAIL release_press: no press strobe within 15 edges"); end
      rel_at = -1;
      for (int k = 1; k <= 60; k++) begin
         if (k == 30) raw[1] = 1'b0;
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL release edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         if (btn_repeat[1]) got.push_back(k);
         if (btn_release[1]) rel_at = k;
      end
      if (REP_EN) want = '{20, 28};
      tests++;
      if (got != want || rel_at != 35)
         begin fails++; $display("[TB] FAIL release_timing: repeats %p release at %0d required %p at 35", got, rel_at, want); end
   endtask

   task automatic test_simultaneous();
      logic [N-1:0] first_press;
      raw = '0;
      for (int t = 0; t < 10; t++) tick();
      raw = 5'b10100;
      first_press = '0;
      for (int t = 0; t < 12; t++) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL simul edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         if (first_press == '0 && btn_press != '0) first_press = btn_press;
      end
      tests++;
      if (first_press !== 5'b10100)
         begin fails++; $display("[TB] FAIL simul_press: first press %b required 10100", first_press); end
   endtask

   task automatic test_long_hold();
      int rcnt;
      int want;
      raw = '0;
      for (int t = 0; t < 10; t++) tick();
      raw[3] = 1'b1;
      for (int t = 0; t < 6; t++) tick();
      rcnt = 0;
      for (int k = 1; k <= 100; k++) begin
         tick();
         tests++;
         if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
            begin fails++; $display("[TB] FAIL longhold edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         rcnt += int'(btn_repeat[3]);
      end
      want = REP_EN ? 11 : 0;
      tests++;
      if (rcnt != want) begin fails++; $display("[TB] FAIL longhold_count: got %0d required %0d", rcnt, want); end
      raw = '0;
      for (int t = 0; t < 10; t++) tick();
   endtask

   task automatic test_random();
      int hold;
      for (int seg = 0; seg < 40; seg++) begin
         raw  = N'($urandom);
         hold = int'($urandom_range(1, 45));
         for (int t = 0; t < hold; t++) begin
            tick();
            tests++;
            if ({btn_level, btn_press, btn_release, btn_repeat} !== {m_level, m_press, m_rel, m_rep})
               begin fails++; $display("[TB] FAIL random edge %0d: got %b_%b_%b_%b required %b_%b_%b_%b", e, btn_level, btn_press, btn_release, btn_repeat, m_level, m_press, m_rel, m_rep); end
         end
      end
   endtask

   initial begin
      test_reset();
      test_bounce();
      test_repeat_hold();
      test_release_repeat();
      test_simultaneous();
      test_long_hold();
      test_random();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
